// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter:
// FSM state encoding and master-id constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter. A lone request wins outright;
// on a tie the master that was not granted last wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic m0_req,
    input  logic m1_req,
    input  logic last_grant,
    output logic winner
);

    // Combinational pick: sole requester, else alternate away from last grant
    always_comb begin
        winner = MID_M0;
        if (m0_req && m1_req) begin
            winner = (last_grant == MID_M1) ? MID_M0 : MID_M1;
        end else if (m1_req) begin
            winner = MID_M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) single-port RAM arbiter.
// IDLE -> SERVE -> RESP, one access per three cycles, Ack two cycles after
// the request is sampled. Build option MEM_ARBITER_ROUND_ROBIN_EN: ties
// alternate between masters; otherwise M1 wins every tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              M0_Req,
    input  logic              M0_WE,
    input  logic [ADDR_W-1:0] M0_Address,
    input  logic [DATA_W-1:0] M0_WriteData,
    output logic              M0_Ack,
    output logic [DATA_W-1:0] M0_ReadData,
    input  logic              M1_Req,
    input  logic              M1_WE,
    input  logic [ADDR_W-1:0] M1_Address,
    input  logic [DATA_W-1:0] M1_WriteData,
    output logic              M1_Ack,
    output logic [DATA_W-1:0] M1_ReadData,
    output logic [ADDR_W-1:0] Ram_Address,
    output logic [DATA_W-1:0] Ram_WriteData,
    output logic              Ram_WE,
    output logic              Ram_RE,
    input  logic [DATA_W-1:0] Ram_ReadData,
    output logic              Busy
);

    state_t              state;
    logic                lat_we;
    logic                lat_mid;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                last_grant;
    logic                winner;
    logic                any_req;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign any_req = M0_Req | M1_Req;

    mem_arb_pick u_pick (
        .m0_req     (M0_Req),
        .m1_req     (M1_Req),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_q;

    // Round-robin pointer: remembers the most recent grant, starts at M1
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q <= MID_M1;
        end else if (state == IDLE && any_req) begin
            last_q <= winner;
        end
    end

    assign last_grant = last_q;
`else
    // Pinning "last" at M0 makes the picker hand every tie to M1.
    assign last_grant = MID_M0;
`endif

    // Steer the winning master's request fields toward the latch registers
    always_comb begin
        sel_we    = M0_WE;
        sel_addr  = M0_Address;
        sel_wdata = M0_WriteData;
        if (winner == MID_M1) begin
            sel_we    = M1_WE;
            sel_addr  = M1_Address;
            sel_wdata = M1_WriteData;
        end
    end

    assign Ram_Address   = lat_addr;
    assign Ram_WriteData = lat_wdata;

    // Arbiter FSM with registered strobes, acks and read-data capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            Ram_WE      <= 1'b0;
            Ram_RE      <= 1'b0;
            M0_Ack      <= 1'b0;
            M1_Ack      <= 1'b0;
            M0_ReadData <= '0;
            M1_ReadData <= '0;
            lat_we      <= 1'b0;
            lat_mid     <= MID_M0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= SERVE;
                        Busy      <= 1'b1;
                        lat_we    <= sel_we;
                        lat_mid   <= winner;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        Ram_WE    <= sel_we;
                        Ram_RE    <= ~sel_we;
                    end
                end
                SERVE: begin
                    state  <= RESP;
                    Ram_WE <= 1'b0;
                    Ram_RE <= 1'b0;
                    M0_Ack <= (lat_mid == MID_M0);
                    M1_Ack <= (lat_mid == MID_M1);
                    if (!lat_we) begin
                        if (lat_mid == MID_M1) begin
                            M1_ReadData <= Ram_ReadData;
                        end else begin
                            M0_ReadData <= Ram_ReadData;
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    M0_Ack <= 1'b0;
                    M1_Ack <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    Ram_WE <= 1'b0;
                    Ram_RE <= 1'b0;
                    M0_Ack <= 1'b0;
                    M1_Ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model of the two
// masters and the arbiter's grant rules predicts RAM strobes, Busy, Acks and
// ReadData; a negedge monitor compares the DUT against the queued predictions.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        M0_Req, M0_WE, M1_Req, M1_WE;
    logic [23:0] M0_Address, M1_Address;
    logic [31:0] M0_WriteData, M1_WriteData;
    logic        M0_Ack, M1_Ack;
    logic [31:0] M0_ReadData, M1_ReadData;
    logic [23:0] Ram_Address;
    logic [31:0] Ram_WriteData;
    logic        Ram_WE, Ram_RE;
    logic [31:0] Ram_ReadData;
    logic        Busy;

    mem_arbiter #(.ADDR_W(24), .DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .M0_Req(M0_Req), .M0_WE(M0_WE), .M0_Address(M0_Address),
        .M0_WriteData(M0_WriteData), .M0_Ack(M0_Ack), .M0_ReadData(M0_ReadData),
        .M1_Req(M1_Req), .M1_WE(M1_WE), .M1_Address(M1_Address),
        .M1_WriteData(M1_WriteData), .M1_Ack(M1_Ack), .M1_ReadData(M1_ReadData),
        .Ram_Address(Ram_Address), .Ram_WriteData(Ram_WriteData),
        .Ram_WE(Ram_WE), .Ram_RE(Ram_RE), .Ram_ReadData(Ram_ReadData),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // RAM: combinational read, write on the rising edge
    logic [31:0] mem [0:255];
    assign Ram_ReadData = mem[Ram_Address[7:0]];
    always @(posedge Clk) if (Ram_WE) mem[Ram_Address[7:0]] <= Ram_WriteData;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct { int cyc; bit we; logic [23:0] addr; logic [31:0] data; } srv_t;
    typedef struct { int cyc; bit mid; logic [31:0] rd0; logic [31:0] rd1; } ack_t;

    srv_t        q_srv[$];
    ack_t        q_ack[$];
    bit          seen[$];
    logic [31:0] ref_mem [0:255];
    bit          pend [2];
    bit          gnt [2];
    bit          p_we [2];
    logic [23:0] p_addr [2];
    logic [31:0] p_data [2];
    int          done_at [2];
    logic [31:0] exp_rd [2];
    int          idle_at = 0;
    bit          last = 1'b1;
    bit          mon_en = 1'b0;

    task automatic model_reset();
        q_srv.delete();
        q_ack.delete();
        idle_at = cyc;
        last = 1'b1;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; gnt[m] = 1'b0; exp_rd[m] = 32'd0; done_at[m] = 0;
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (gnt[m] && cyc >= done_at[m]) begin
                pend[m] = 1'b0;
                gnt[m]  = 1'b0;
            end
        end
    endtask

    task automatic issue(input int m, input bit we, input logic [23:0] addr, input logic [31:0] data);
        if (!pend[m]) begin
            pend[m] = 1'b1; p_we[m] = we; p_addr[m] = addr; p_data[m] = data;
        end
    endtask

    // Drive the pins for this cycle and apply the arbitration rules to them
    task automatic commit();
        bit c0, c1, w;
        M0_Req = pend[0]; M0_WE = p_we[0]; M0_Address = p_addr[0]; M0_WriteData = p_data[0];
        M1_Req = pend[1]; M1_WE = p_we[1]; M1_Address = p_addr[1]; M1_WriteData = p_data[1];
        if (cyc >= idle_at) begin
            c0 = pend[0] && !gnt[0];
            c1 = pend[1] && !gnt[1];
            if (c0 || c1) begin
                if (c0 && c1) w = RR ? ~last : 1'b1;
                else          w = c1;
                last       = w;
                gnt[w]     = 1'b1;
                done_at[w] = cyc + 3;
                idle_at    = cyc + 3;
                if (p_we[w]) ref_mem[p_addr[w][7:0]] = p_data[w];
                else         exp_rd[w] = ref_mem[p_addr[w][7:0]];
                q_srv.push_back('{cyc: cyc + 1, we: p_we[w], addr: p_addr[w], data: p_data[w]});
                q_ack.push_back('{cyc: cyc + 2, mid: w, rd0: exp_rd[0], rd1: exp_rd[1]});
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (pend[0] || pend[1] || q_ack.size() != 0); i++) begin
            next_cycle();
            commit();
        end
        chk("drain_done", 64'({pend[0], pend[1], q_ack.size() != 0}), 64'd0);
    endtask

    // Monitor: compare DUT outputs against the model's predictions each cycle
    srv_t sv;
    ack_t ak;
    always @(negedge Clk) begin
        if (mon_en) begin
            if (q_srv.size() != 0 && q_srv[0].cyc == cyc) begin
                sv = q_srv.pop_front();
                chk("ram_we", 64'(Ram_WE), 64'(sv.we));
                chk("ram_re", 64'(Ram_RE), 64'(!sv.we));
                chk("ram_addr", 64'(Ram_Address), 64'(sv.addr));
                chk("ram_wdata", 64'(Ram_WriteData), 64'(sv.data));
            end else begin
                chk("ram_strobes_off", 64'({Ram_WE, Ram_RE}), 64'd0);
            end
            chk("busy", 64'(Busy), 64'((cyc >= idle_at - 2) && (cyc < idle_at)));
            if (q_ack.size() != 0 && q_ack[0].cyc == cyc) begin
                ak = q_ack.pop_front();
                chk("m0_ack", 64'(M0_Ack), 64'(ak.mid == 1'b0));
                chk("m1_ack", 64'(M1_Ack), 64'(ak.mid == 1'b1));
                chk("m0_readdata", 64'(M0_ReadData), 64'(ak.rd0));
                chk("m1_readdata", 64'(M1_ReadData), 64'(ak.rd1));
            end else begin
                chk("no_ack", 64'({M0_Ack, M1_Ack}), 64'd0);
            end
            if (M0_Ack ^ M1_Ack) seen.push_back(M1_Ack);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        mem[9]     = 32'h1234_5678;
        ref_mem[9] = 32'h1234_5678;
        for (int m = 0; m < 2; m++) begin
            p_we[m] = 1'b0; p_addr[m] = 24'd0; p_data[m] = 32'd0;
        end
        Reset = 1'b1;
        M0_Req = 1'b0; M0_WE = 1'b0; M0_Address = '0; M0_WriteData = '0;
        M1_Req = 1'b0; M1_WE = 1'b0; M1_Address = '0; M1_WriteData = '0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();

        // Reset state
        chk("rst_m0_ack", 64'(M0_Ack), 64'd0);
        chk("rst_m1_ack", 64'(M1_Ack), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_ram_we", 64'(Ram_WE), 64'd0);
        chk("rst_ram_re", 64'(Ram_RE), 64'd0);
        chk("rst_m0_rd", 64'(M0_ReadData), 64'd0);
        chk("rst_m1_rd", 64'(M1_ReadData), 64'd0);
        chk("rst_ram_addr", 64'(Ram_Address), 64'd0);
        chk("rst_ram_wdata", 64'(Ram_WriteData), 64'd0);
        mon_en = 1'b1;

        // M0 read of address 9
        issue(0, 1'b0, 24'h000009, 32'h0);
        commit();
        drain();
        chk("m0_read_9", 64'(M0_ReadData), 64'h1234_5678);
        chk("m1_rd_untouched", 64'(M1_ReadData), 64'd0);

        // M1 write then M0 read-back of address 0xA
        next_cycle();
        issue(1, 1'b1, 24'h00000A, 32'hDEAD_BEEF);
        commit();
        drain();
        next_cycle();
        issue(0, 1'b0, 24'h00000A, 32'h5555_0000);
        commit();
        drain();
        chk("m0_readback_a", 64'(M0_ReadData), 64'hDEAD_BEEF);

        // M0 request raised while M1 is in SERVE
        next_cycle();
        issue(1, 1'b0, 24'h000003, 32'h0);
        commit();
        next_cycle();
        issue(0, 1'b0, 24'h000004, 32'h0);
        commit();
        drain();

        // Reset pulsed during SERVE of an M1 write
        next_cycle();
        issue(1, 1'b1, 24'h00000B, 32'hCAFE_F00D);
        commit();
        next_cycle();
        Reset = 1'b1;
        pend[1] = 1'b0;
        gnt[1] = 1'b0;
        commit();
        next_cycle();
        Reset = 1'b0;
        model_reset();
        commit();
        chk("rst_write_kept", 64'(mem[11]), 64'hCAFE_F00D);
        chk("rst_mid_m1_ack", 64'(M1_Ack), 64'd0);
        chk("rst_mid_busy", 64'(Busy), 64'd0);
        chk("rst_mid_strobes", 64'({Ram_WE, Ram_RE}), 64'd0);
        chk("rst_mid_rd", 64'({M0_ReadData, M1_ReadData}), 64'd0);
        chk("rst_mid_ram_addr", 64'(Ram_Address), 64'd0);
        chk("rst_mid_ram_wdata", 64'(Ram_WriteData), 64'd0);
        ref_mem[11] = 32'hCAFE_F00D;

        // Both masters request together and keep requesting
        seen.delete();
        for (int i = 0; i < 12; i++) begin
            if (i != 0) next_cycle();
            issue(0, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 15)), $urandom);
            issue(1, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 15)), $urandom);
            commit();
        end
        drain();
        chk("tie_grant_count", 64'(seen.size() >= 4), 64'd1);
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            chk($sformatf("tie_grant_%0d", k), 64'(seen[k]), RR ? 64'(k % 2) : 64'd1);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) != 0)
                    issue(m, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 15)), $urandom);
            end
            commit();
        end
        drain();
        next_cycle();
        commit();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data word width.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 M0_Req / M1_Req  input  1  SHALL be the access request from master 0 (fetch) / master 1 (data).
REQ-006 M0_WE / M1_WE  input  1  SHALL select write (1) or read (0); valid while Req is high.
REQ-007 M0_Address / M1_Address  input  ADDR_W  SHALL be the word address.
REQ-008 M0_WriteData / M1_WriteData  input  DATA_W  SHALL be the write data.
REQ-009 M0_Ack / M1_Ack  output  1  SHALL be a one-cycle completion pulse.
REQ-010 M0_ReadData / M1_ReadData  output  DATA_W  SHALL be the registered read result.
REQ-011 Ram_Address  output  ADDR_W, Ram_WriteData  output  DATA_W, Ram_WE  output  1, Ram_RE  output  1 SHALL drive the RAM.
REQ-012 Ram_ReadData  input  DATA_W  SHALL be the RAM's combinational read data.
REQ-013 Busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SERVE and RESP; IDLE->SERVE when any Req is high; SERVE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-015 In IDLE with a Req high, the winner's WE, Address, WriteData and master id SHALL be latched into internal registers at the clock edge.
REQ-016 In SERVE, Ram_Address and Ram_WriteData SHALL be driven from the latched registers, with Ram_WE = latched WE and Ram_RE = !latched WE.
REQ-017 Ram_WE and Ram_RE SHALL be 0 in IDLE and RESP; Ram_Address and Ram_WriteData SHALL hold their latched values.
REQ-018 On a read, Ram_ReadData SHALL be captured at the end of SERVE into the winner's ReadData; the other master's ReadData SHALL be unchanged.
REQ-019 On a write, the winner's ReadData SHALL be unchanged.
REQ-020 In RESP, exactly the winner's Ack SHALL be high for one cycle; latency is Req sampled in cycle N -> Ack in cycle N+2.
REQ-021 Maximum throughput SHALL be one access per 3 cycles.
REQ-022 A master SHALL hold Req, WE, Address and WriteData stable until its Ack; it SHALL drop Req on the edge where Ack is seen or request again.
REQ-023 Req inputs SHALL be ignored in SERVE and RESP; a Req that rises then is serviced from the next IDLE.
REQ-024 When only one Req is high, that master SHALL win.
REQ-025 Tie-break on simultaneous Reqs SHALL follow REQ-030 / REQ-031.

Reset
REQ-026 Reset SHALL force state IDLE; all Acks 0; Ram_WE and Ram_RE 0; Busy 0; both ReadData outputs, Ram_Address, Ram_WriteData and the latched registers 0; round-robin pointer "last = M1".
REQ-027 Reset asserted during SERVE of a write SHALL NOT suppress that write, since the RAM samples WE on the same edge.
REQ-028 Reset asserted during SERVE or RESP SHALL suppress the pending Ack, and no ReadData update SHALL occur.
REQ-029 Reset SHALL take priority over every other transition.

Configuration
REQ-030 With MEM_ARBITER_ROUND_ROBIN_EN defined, a tie SHALL go to the master not granted last; the pointer SHALL update on every grant; the first tie after reset goes to M0.
REQ-031 Without MEM_ARBITER_ROUND_ROBIN_EN, a tie SHALL always go to M1 (fixed priority), and no pointer register SHALL exist.

Structure
REQ-032 Package mem_arbiter_pkg SHALL hold the state encoding (IDLE=2'b00, SERVE=2'b01, RESP=2'b10) and master-id constants (MID_M0=0, MID_M1=1).
REQ-033 Tie-break logic SHALL be in one sub-module mem_arb_pick: inputs the two Reqs and the last-grant pointer, output the winner id.

Verification
REQ-034 Reset, then M0 read of addr 0x000009 holding 0x12345678 -> Ram_RE=1 in cycle 1, M0_Ack in cycle 2, M0_ReadData=0x12345678, M1_ReadData=0.
REQ-035 M1 write 0xDEADBEEF to 0x00000A, then M0 read of 0x00000A -> Ram_WE exactly one cycle, M1_Ack once, M0_ReadData=0xDEADBEEF.
REQ-036 Both Reqs rise in the same cycle and are held, round-robin build -> grants M0, M1, M0, M1; fixed build -> M1 serviced first every tie.
REQ-037 M0_Req rises during an M1 SERVE -> ignored until IDLE, then M0_Ack exactly 2 cycles after that IDLE.
REQ-038 Reset pulsed during SERVE of an M1 write of 0xCAFEF00D to 0x00000B -> Mem[0x00000B]=0xCAFEF00D, no M1_Ack, next cycle IDLE with all outputs at reset values.
